spi_master_tx: RTL

Serial frame transmitter that drives the sclk/cs_n/mosi lines consumed by the slave-side sclk edge detection and shift logic. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) with programmable sclk division. It captures miso full-duplex and returns the received word with a one-cycle strobe. It is the bench and loopback driver for the slave receive path, and the master-side port for board-level links.

---
 rtl/spi_master_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts a parallel word out MSB-first on mosi and captures miso full-duplex.
// Frame sequence is IDLE -> SETUP -> SHIFT -> HOLD -> GAP, each phase paced by the sclk divider.
module spi_master_tx #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  output logic             cs_n,
  output logic             busy
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned EdgeW = $clog2(2 * WIDTH + 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             div_done;

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    div_done   = (div_q == DivLast);
    div_d      = div_done ? '0 : div_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (tx_valid && tx_ready_q) begin
          // The shift register holds the bits still to come after the MSB now on mosi.
          tx_sr_d = {tx_data[WIDTH-2:0], 1'b0};
          rx_sr_d = '0;
          edge_d  = '0;
          mosi_d  = tx_data[WIDTH-1];
          cs_n_d  = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (div_done) state_d = StShift;
      end
      StShift: begin
        if (div_done) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (!sclk_q) begin
            rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
          end else if (edge_q != EdgeLast) begin
            mosi_d  = tx_sr_q[WIDTH-1];
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
          end
          if (edge_q == EdgeLast) state_d = StHold;
        end
      end
      StHold: begin
        if (div_done) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          mosi_d     = 1'b0;
          state_d    = StGap;
        end
      end
      StGap: begin
        if (div_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    tx_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign busy     = busy_q;

endmodule
